// File: rtl/xbar_ctrl_arbiter_if.sv
// Handshake bundle between the crossbar datapath and its control arbiter.
// The slave modport is the arbiter's view; master is the crossbar/environment view.
interface xbar_ctrl_arbiter_if #(
  parameter int unsigned BIT_WIDTH         = 32,
  parameter int unsigned N_INPUTS          = 2,
  parameter int unsigned CONTROL_BIT_WIDTH = 42
) ();
  logic [N_INPUTS-1:0][BIT_WIDTH-1:0] req_msg;
  logic [N_INPUTS-1:0]                req_val;
  logic [N_INPUTS-1:0]                fire_rdy;
  logic [CONTROL_BIT_WIDTH-1:0]       control;
  logic                               control_val;
  logic                               control_rdy;
  logic [N_INPUTS-1:0]                grant;
  logic                               busy;

  modport slave (
    input  req_msg,
    input  req_val,
    input  fire_rdy,
    input  control_rdy,
    output control,
    output control_val,
    output grant,
    output busy
  );

  modport master (
    output req_msg,
    output req_val,
    output fire_rdy,
    output control_rdy,
    input  control,
    input  control_val,
    input  grant,
    input  busy
  );
endinterface

// File: rtl/xbar_ctrl_arbiter.sv
// Round-robin arbiter that grants one crossbar input at a time and issues
// the matching input/output select word to the crossbar.
module xbar_ctrl_arbiter #(
  parameter int unsigned BIT_WIDTH         = 32,
  parameter int unsigned N_INPUTS          = 2,
  parameter int unsigned N_OUTPUTS         = 2,
  parameter int unsigned CONTROL_BIT_WIDTH = 42
) (
  input  logic                clk,
  input  logic                reset,
  xbar_ctrl_arbiter_if.slave  arb
);

  localparam int unsigned SI = $clog2(N_INPUTS);
  localparam int unsigned SO = $clog2(N_OUTPUTS);

  typedef enum logic [1:0] {StIdle, StIssue, StXfer} state_e;

  state_e          r_state, w_state_next;
  logic [SI-1:0]   r_rr_ptr, w_rr_ptr_next;
  logic [SI-1:0]   r_g, w_g_next;
  logic [SO-1:0]   r_dest, w_dest_next;
  logic            w_any_req;
  logic [SI-1:0]   w_winner;

  // Descending scan so the lowest offset from rr_ptr is the last (winning) write.
  always_comb begin
    w_any_req = 1'b0;
    w_winner  = r_rr_ptr;
    for (int k = N_INPUTS - 1; k >= 0; k--) begin
      if (arb.req_val[r_rr_ptr + SI'(k)]) begin
        w_any_req = 1'b1;
        w_winner  = r_rr_ptr + SI'(k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= StIdle;
      r_rr_ptr <= '0;
      r_g      <= '0;
      r_dest   <= '0;
    end else begin
      r_state  <= w_state_next;
      r_rr_ptr <= w_rr_ptr_next;
      r_g      <= w_g_next;
      r_dest   <= w_dest_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_rr_ptr_next = r_rr_ptr;
    w_g_next      = r_g;
    w_dest_next   = r_dest;
    unique case (r_state)
      StIdle: begin
        if (w_any_req) begin
          w_state_next = StIssue;
          w_g_next     = w_winner;
          w_dest_next  = arb.req_msg[w_winner][BIT_WIDTH-1 -: SO];
        end
      end
      StIssue: begin
        if (arb.control_rdy) w_state_next = StXfer;
      end
      StXfer: begin
        if (arb.req_val[r_g] && arb.fire_rdy[r_g]) begin
          w_state_next  = StIdle;
          w_rr_ptr_next = r_g + SI'(1);
        end else if (!arb.req_val[r_g]) begin
          // Aborted packet: give up ownership without advancing fairness pointer.
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    arb.control_val = (r_state == StIssue);
    arb.busy        = (r_state == StIssue) || (r_state == StXfer);
    arb.grant       = '0;
    if (arb.busy) arb.grant[r_g] = 1'b1;
    arb.control                                = '0;
    arb.control[CONTROL_BIT_WIDTH-1 -: SI]     = r_g;
    arb.control[CONTROL_BIT_WIDTH-SI-1 -: SO]  = r_dest;
  end

endmodule

// File: tb/tb_xbar_ctrl_arbiter.sv
// Self-checking bench for xbar_ctrl_arbiter: directed scenarios plus random
// traffic compared against a transaction-level ownership model.
module tb_xbar_ctrl_arbiter;
  localparam int BW = 32;
  localparam int NI = 2;
  localparam int NO = 2;
  localparam int CW = 42;
  localparam int SI = 1;
  localparam int SO = 1;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  // Model: owner < 0 means nobody holds the crossbar; issued says the word was accepted.
  int m_ptr, m_owner, m_issued, m_g, m_d;

  xbar_ctrl_arbiter_if #(.BIT_WIDTH(BW), .N_INPUTS(NI), .CONTROL_BIT_WIDTH(CW)) bus ();

  xbar_ctrl_arbiter #(
    .BIT_WIDTH(BW), .N_INPUTS(NI), .N_OUTPUTS(NO), .CONTROL_BIT_WIDTH(CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .arb   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_update(input logic rst, input logic [NI-1:0] rv,
                                       input logic [NI-1:0] fr, input logic crdy,
                                       input logic [NI-1:0][BW-1:0] msg);
    bit found;
    if (rst) begin
      m_ptr = 0; m_owner = -1; m_issued = 0; m_g = 0; m_d = 0;
    end else if (m_owner < 0) begin
      found = 0;
      for (int k = 0; k < NI; k++) begin
        int idx;
        idx = (m_ptr + k) % NI;
        if (rv[idx] && !found) begin
          found = 1; m_owner = idx; m_g = idx; m_issued = 0;
          m_d = int'(msg[idx] >> (BW - SO));
        end
      end
    end else if (!m_issued) begin
      if (crdy) m_issued = 1;
    end else if (rv[m_owner] && fr[m_owner]) begin
      m_ptr = (m_owner + 1) % NI;
      m_owner = -1;
    end else if (!rv[m_owner]) begin
      m_owner = -1;
    end
  endfunction

  function automatic logic [CW-1:0] model_control();
    return (CW'(m_g) << (CW - SI)) | (CW'(m_d) << (CW - SI - SO));
  endfunction

  function automatic logic [NI-1:0] model_grant();
    logic [NI-1:0] g;
    g = '0;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return g;
  endfunction

  task automatic tick();
    logic [NI-1:0]         rv, fr;
    logic                  crdy, rst;
    logic [NI-1:0][BW-1:0] msg;
    rv = bus.req_val; fr = bus.fire_rdy; crdy = bus.control_rdy; rst = reset;
    msg = bus.req_msg;
    @(posedge clk);
    model_update(rst, rv, fr, crdy, msg);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.req_val = '0; bus.fire_rdy = '0; bus.control_rdy = 1'b0;
    for (int i = 0; i < NI; i++) bus.req_msg[i] = $urandom;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.req_val = 2'b11; bus.fire_rdy = 2'b11; bus.control_rdy = 1'b1;
    tick();
    checks++; if (bus.control_val !== 1'b0) begin errors++;
      $display("FAIL reset_cval: got %b want 0", bus.control_val); end
    checks++; if (bus.control !== '0) begin errors++;
      $display("FAIL reset_control: got %h want 0", bus.control); end
    checks++; if (bus.grant !== 2'b00) begin errors++;
      $display("FAIL reset_grant: got %b want 00", bus.grant); end
    checks++; if (bus.busy !== 1'b0) begin errors++;
      $display("FAIL reset_busy: got %b want 0", bus.busy); end
    reset = 1'b0;
  endtask

  task automatic test_single();
    logic [CW-1:0] want;
    want = '0; want[CW-2] = 1'b1;
    do_reset();
    bus.req_val = 2'b01; bus.control_rdy = 1'b1; bus.fire_rdy = 2'b00;
    bus.req_msg[0] = {1'b1, 31'($urandom)};
    tick();
    checks++; if (bus.control_val !== 1'b1) begin errors++;
      $display("FAIL single_cval: got %b want 1", bus.control_val); end
    checks++; if (bus.control !== want) begin errors++;
      $display("FAIL single_control: got %h want %h", bus.control, want); end
    checks++; if (bus.grant !== 2'b01) begin errors++;
      $display("FAIL single_grant: got %b want 01", bus.grant); end
    bus.fire_rdy = 2'b01;
    tick();
    checks++; if (bus.control_val !== 1'b0 || bus.busy !== 1'b1 || bus.grant !== 2'b01) begin
      errors++; $display("FAIL single_xfer: got cval=%b busy=%b grant=%b want 0 1 01",
                         bus.control_val, bus.busy, bus.grant); end
    tick();
    checks++; if (bus.busy !== 1'b0 || bus.grant !== 2'b00) begin errors++;
      $display("FAIL single_idle: got busy=%b grant=%b want 0 00", bus.busy, bus.grant); end
    bus.req_val = 2'b11;
    tick();
    checks++; if (bus.grant !== 2'b10) begin errors++;
      $display("FAIL single_ptr: got grant %b want 10", bus.grant); end
  endtask

  task automatic test_round_robin();
    int n;
    n = 0;
    do_reset();
    bus.req_val = 2'b11; bus.fire_rdy = 2'b11; bus.control_rdy = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (bus.control_val === 1'b1) begin
        checks++; if (bus.grant !== ((n % 2) ? 2'b10 : 2'b01)) begin errors++;
          $display("FAIL rr_grant[%0d]: got %b want %b", n, bus.grant,
                   (n % 2) ? 2'b10 : 2'b01); end
        checks++; if (bus.control[CW-1] !== 1'((n % 2))) begin errors++;
          $display("FAIL rr_bit41[%0d]: got %b want %0d", n, bus.control[CW-1], n % 2); end
        checks++; if (c != 3 * n) begin errors++;
          $display("FAIL rr_period[%0d]: issued at cycle %0d want %0d", n, c, 3 * n); end
        n++;
      end
    end
    checks++; if (n != 4) begin errors++;
      $display("FAIL rr_count: got %0d issues want 4", n); end
  endtask

  task automatic test_backpressure();
    logic [CW-1:0] first;
    do_reset();
    bus.req_val = 2'b01; bus.control_rdy = 1'b0; bus.fire_rdy = 2'b00;
    bus.req_msg[0] = $urandom;
    tick();
    first = bus.control;
    for (int c = 0; c < 5; c++) begin
      bus.req_msg[0] = $urandom;
      tick();
      checks++; if (bus.control_val !== 1'b1 || bus.control !== first) begin errors++;
        $display("FAIL bp_hold[%0d]: got cval=%b ctrl=%h want 1 %h", c,
                 bus.control_val, bus.control, first); end
    end
    bus.control_rdy = 1'b1;
    tick();
    checks++; if (bus.control_val !== 1'b0 || bus.busy !== 1'b1 || bus.grant !== 2'b01) begin
      errors++; $display("FAIL bp_xfer: got cval=%b busy=%b grant=%b want 0 1 01",
                         bus.control_val, bus.busy, bus.grant); end
  endtask

  task automatic test_abort();
    do_reset();
    bus.req_val = 2'b01; bus.control_rdy = 1'b1; bus.fire_rdy = 2'b01;
    tick(); tick(); tick();
    bus.req_val = 2'b10; bus.fire_rdy = 2'b00;
    tick();
    checks++; if (bus.grant !== 2'b10) begin errors++;
      $display("FAIL abort_win: got grant %b want 10", bus.grant); end
    tick();
    bus.req_val = 2'b00;
    tick();
    checks++; if (bus.busy !== 1'b0 || bus.grant !== 2'b00) begin errors++;
      $display("FAIL abort_idle: got busy=%b grant=%b want 0 00", bus.busy, bus.grant); end
    bus.req_val = 2'b11;
    tick();
    checks++; if (bus.grant !== 2'b10) begin errors++;
      $display("FAIL abort_ptr: got grant %b want 10", bus.grant); end
  endtask

  task automatic test_reset_mid_xfer();
    do_reset();
    bus.req_val = 2'b01; bus.control_rdy = 1'b1; bus.fire_rdy = 2'b01;
    tick(); tick(); tick();
    bus.req_val = 2'b10; bus.fire_rdy = 2'b00;
    tick(); tick();
    checks++; if (bus.busy !== 1'b1 || bus.control_val !== 1'b0) begin errors++;
      $display("FAIL rst_pre: got busy=%b cval=%b want 1 0", bus.busy, bus.control_val); end
    reset = 1'b1;
    tick();
    checks++; if (bus.control_val !== 1'b0 || bus.grant !== 2'b00 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL rst_mid: got cval=%b grant=%b busy=%b want 0 00 0",
                         bus.control_val, bus.grant, bus.busy); end
    reset = 1'b0; bus.req_val = 2'b00;
    tick();
    checks++; if (bus.control_val !== 1'b0 || bus.busy !== 1'b0) begin errors++;
      $display("FAIL rst_reissue: got cval=%b busy=%b want 0 0", bus.control_val, bus.busy); end
    bus.req_val = 2'b10;
    tick();
    checks++; if (bus.control_val !== 1'b1 || bus.control[CW-1] !== 1'b1 ||
                  bus.grant !== 2'b10) begin
      errors++; $display("FAIL rst_newreq: got cval=%b bit41=%b grant=%b want 1 1 10",
                         bus.control_val, bus.control[CW-1], bus.grant); end
    bus.req_val = 2'b00;
    tick(); tick();
    bus.req_val = 2'b11;
    tick();
    checks++; if (bus.grant !== 2'b01) begin errors++;
      $display("FAIL rst_ptr: got grant %b want 01", bus.grant); end
  endtask

  task automatic test_header_change();
    do_reset();
    bus.req_val = 2'b01; bus.control_rdy = 1'b0; bus.fire_rdy = 2'b00;
    bus.req_msg[0] = {1'b0, 31'($urandom)};
    tick();
    bus.req_msg[0] = {1'b1, 31'($urandom)};
    bus.req_msg[1] = $urandom;
    bus.req_val = 2'b11;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (bus.control[CW-2] !== 1'b0 || bus.control[CW-1] !== 1'b0 ||
                    bus.grant !== 2'b01) begin
        errors++; $display("FAIL hdr_hold[%0d]: got sel=%b%b grant=%b want 00 01", c,
                           bus.control[CW-1], bus.control[CW-2], bus.grant); end
    end
    bus.control_rdy = 1'b1;
    tick();
    checks++; if (bus.grant !== 2'b01 || bus.busy !== 1'b1) begin errors++;
      $display("FAIL hdr_xfer: got grant=%b busy=%b want 01 1", bus.grant, bus.busy); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      bus.req_val     = NI'($urandom);
      bus.fire_rdy    = NI'($urandom);
      bus.control_rdy = 1'($urandom);
      for (int i = 0; i < NI; i++) bus.req_msg[i] = $urandom;
      reset = ($urandom_range(0, 39) == 0);
      tick();
      checks++; if (bus.busy !== (m_owner >= 0)) begin errors++;
        $display("FAIL rand_busy[%0d]: got %b want %b", c, bus.busy, m_owner >= 0); end
      checks++; if (bus.control_val !== (m_owner >= 0 && m_issued == 0)) begin errors++;
        $display("FAIL rand_cval[%0d]: got %b want %b", c, bus.control_val,
                 (m_owner >= 0 && m_issued == 0)); end
      checks++; if (bus.grant !== model_grant()) begin errors++;
        $display("FAIL rand_grant[%0d]: got %b want %b", c, bus.grant, model_grant()); end
      if (m_owner >= 0 && m_issued == 0) begin
        checks++; if (bus.control !== model_control()) begin errors++;
          $display("FAIL rand_control[%0d]: got %h want %h", c, bus.control,
                   model_control()); end
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0;
    m_ptr = 0; m_owner = -1; m_issued = 0; m_g = 0; m_d = 0;
    reset = 1'b1;
    bus.req_val = '0; bus.fire_rdy = '0; bus.control_rdy = 1'b0; bus.req_msg = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_abort();
    test_reset_mid_xfer();
    test_header_change();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
